// File: rtl/seq_alu_unit.sv
// Multi-cycle EX-stage ALU: single-cycle logic/arith/compare ops,
// bit-serial shifts, result returned over a valid/ready handshake.
module seq_alu_unit #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       Operation,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALUResult,
    output logic             Zero
);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_XOR = 4'b0010;
    localparam logic [3:0] OP_ADD = 4'b0011;
    localparam logic [3:0] OP_SUB = 4'b0100;
    localparam logic [3:0] OP_SRL = 4'b0101;
    localparam logic [3:0] OP_SRA = 4'b0110;
    localparam logic [3:0] OP_SLL = 4'b0111;
    localparam logic [3:0] OP_EQ  = 4'b1000;
    localparam logic [3:0] OP_NE  = 4'b1001;
    localparam logic [3:0] OP_LT  = 4'b1010;
    localparam logic [3:0] OP_GE  = 4'b1011;
    localparam logic [3:0] OP_LUI = 4'b1100;

    localparam logic [1:0] SH_SRL = 2'b01;
    localparam logic [1:0] SH_SRA = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic [1:0]         op_q, op_d;

    logic [WIDTH-1:0]   alu_res;
    logic [WIDTH-1:0]   acc_step;
    logic [SHAMT_W-1:0] shamt;
    logic               is_shift;
    logic               cmp_lt;

    assign shamt    = SrcB[SHAMT_W-1:0];
    assign is_shift = (Operation == OP_SRL) ||
                      (Operation == OP_SRA) ||
                      (Operation == OP_SLL);
    assign cmp_lt   = $signed(SrcA) < $signed(SrcB);

    // Single-cycle datapath for everything except shifts.
    always_comb begin
        alu_res = '0;
        unique case (1'b1)
            Operation == OP_AND: alu_res = SrcA & SrcB;
            Operation == OP_OR:  alu_res = SrcA | SrcB;
            Operation == OP_XOR: alu_res = SrcA ^ SrcB;
            Operation == OP_ADD: alu_res = SrcA + SrcB;
            Operation == OP_SUB: alu_res = SrcA - SrcB;
            Operation == OP_EQ:
                alu_res = {{(WIDTH-1){1'b0}}, SrcA == SrcB};
            Operation == OP_NE:
                alu_res = {{(WIDTH-1){1'b0}}, SrcA != SrcB};
            Operation == OP_LT:
                alu_res = {{(WIDTH-1){1'b0}}, cmp_lt};
            Operation == OP_GE:
                alu_res = {{(WIDTH-1){1'b0}}, !cmp_lt};
            Operation == OP_LUI: alu_res = SrcB;
            default:             alu_res = '0;
        endcase
    end

    // One bit of shift per SHIFT cycle on the latched direction.
    always_comb begin
        acc_step = '0;
        unique case (op_q)
            SH_SRL:  acc_step = {1'b0, acc_q[WIDTH-1:1]};
            SH_SRA:  acc_step = {acc_q[WIDTH-1], acc_q[WIDTH-1:1]};
            default: acc_step = {acc_q[WIDTH-2:0], 1'b0};
        endcase
    end

    always_comb begin
        state_d = state_q;
        res_d   = res_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        if (flush) begin
            state_d = IDLE;
            res_d   = '0;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        if (!is_shift) begin
                            res_d   = alu_res;
                            state_d = DONE;
                        end else if (shamt == '0) begin
                            res_d   = SrcA;
                            state_d = DONE;
                        end else begin
                            acc_d   = SrcA;
                            cnt_d   = shamt;
                            op_d    = Operation[1:0];
                            state_d = SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    acc_d = acc_step;
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == SHAMT_W'(1)) begin
                        res_d   = acc_step;
                        state_d = DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            res_q   <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
        end
    end

    assign in_ready  = (state_q == IDLE) && !flush;
    assign out_valid = (state_q == DONE);
    assign ALUResult = res_q;
    assign Zero      = (res_q == '0);

endmodule

// File: tb/tb_seq_alu_unit.sv
// Bench for seq_alu_unit: transaction-level reference model checked
// every cycle, plus directed literal cases and randomized traffic.
module tb_seq_alu_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  Operation;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] ALUResult;
    logic        Zero;

    int vectors = 0;
    int errors  = 0;
    bit chk_en  = 1'b0;

    seq_alu_unit #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Operation (Operation),
        .SrcA      (SrcA),
        .SrcB      (SrcB),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ALUResult (ALUResult),
        .Zero      (Zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_fn(input logic [3:0] op,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
        int sh;
        sh = int'(b[4:0]);
        case (op)
            4'd0:  return a & b;
            4'd1:  return a | b;
            4'd2:  return a ^ b;
            4'd3:  return a + b;
            4'd4:  return a - b;
            4'd5:  return a >> sh;
            4'd6:  return 32'($signed(a) >>> sh);
            4'd7:  return a << sh;
            4'd8:  return (a == b) ? 32'd1 : 32'd0;
            4'd9:  return (a != b) ? 32'd1 : 32'd0;
            4'd10: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd11: return ($signed(a) >= $signed(b)) ? 32'd1 : 32'd0;
            4'd12: return b;
            default: return 32'd0;
        endcase
    endfunction

    // Transaction model: a request occupies the unit for a number of
    // edges (shamt extra edges for a nonzero shift), then presents.
    bit          m_valid = 1'b0;
    int          m_wait  = 0;
    logic [31:0] m_res   = 32'd0;
    logic [31:0] m_pend  = 32'd0;

    always @(posedge clk) begin
        if (!rst_n || flush) begin
            m_valid = 1'b0;
            m_wait  = 0;
            m_res   = 32'd0;
        end else if (m_valid) begin
            if (out_ready) m_valid = 1'b0;
        end else if (m_wait > 0) begin
            m_wait--;
            if (m_wait == 0) begin
                m_valid = 1'b1;
                m_res   = m_pend;
            end
        end else if (in_valid) begin
            m_pend = ref_fn(Operation, SrcA, SrcB);
            if (Operation inside {4'd5, 4'd6, 4'd7})
                m_wait = int'(SrcB[4:0]);
            else
                m_wait = 0;
            if (m_wait == 0) begin
                m_valid = 1'b1;
                m_res   = m_pend;
            end
        end
    end

    always @(negedge clk) begin
        #2;
        if (chk_en) begin
            chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
            chk("in_ready", {31'd0, in_ready},
                {31'd0, !m_valid && m_wait == 0 && !flush});
            chk("ALUResult", ALUResult, m_res);
            chk("Zero", {31'd0, Zero}, {31'd0, m_res == 32'd0});
        end
    end

    task automatic run_op(input string name, input logic [3:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int lat);
        int k;
        @(negedge clk);
        Operation = op;
        SrcA      = a;
        SrcB      = b;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        chk({name, ".rdy"}, {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        k = 0;
        while (!out_valid && k < 40) begin
            @(negedge clk);
            k++;
        end
        #1;
        chk({name, ".vld"}, {31'd0, out_valid}, 32'd1);
        chk({name, ".lat"}, 32'(k), 32'(lat));
        chk({name, ".res"}, ALUResult, exp);
        chk({name, ".z"}, {31'd0, Zero}, {31'd0, exp == 32'd0});
    endtask

    task automatic abort_shift(input string name, input bit use_rst);
        bit seen;
        @(negedge clk);
        Operation = 4'b0111;
        SrcA      = 32'd1;
        SrcB      = 32'd20;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        seen     = 1'b0;
        repeat (6) begin
            @(negedge clk);
            seen |= out_valid;
        end
        if (use_rst) rst_n = 1'b0;
        else         flush = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        flush = 1'b0;
        #1;
        chk({name, ".vld"}, {31'd0, out_valid}, 32'd0);
        chk({name, ".res"}, ALUResult, 32'd0);
        chk({name, ".z"}, {31'd0, Zero}, 32'd1);
        chk({name, ".rdy"}, {31'd0, in_ready}, 32'd1);
        repeat (25) begin
            @(negedge clk);
            seen |= out_valid;
        end
        chk({name, ".never"}, {31'd0, seen}, 32'd0);
    endtask

    initial begin
        logic [31:0] held;
        int k;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        Operation = 4'd0;
        SrcA      = 32'd0;
        SrcB      = 32'd0;
        flush     = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        chk_en = 1'b1;
        #1;
        chk("rst.res", ALUResult, 32'd0);
        chk("rst.z", {31'd0, Zero}, 32'd1);
        chk("rst.vld", {31'd0, out_valid}, 32'd0);
        chk("rst.rdy", {31'd0, in_ready}, 32'd1);

        run_op("add_ovf", 4'b0011, 32'h7FFFFFFF, 32'd1, 32'h80000000, 0);
        run_op("add_wrap", 4'b0011, 32'hFFFFFFFF, 32'd1, 32'h0, 0);
        run_op("sra4", 4'b0110, 32'hF0000000, 32'd4, 32'hFF000000, 4);
        run_op("srl4", 4'b0101, 32'hF0000000, 32'd4, 32'h0F000000, 4);
        run_op("sll31", 4'b0111, 32'd1, 32'd31, 32'h80000000, 31);
        run_op("sll0", 4'b0111, 32'h1234, 32'h20, 32'h1234, 0);
        run_op("lt", 4'b1010, 32'hFFFFFFFF, 32'd1, 32'd1, 0);
        run_op("ge", 4'b1011, 32'hFFFFFFFF, 32'd1, 32'd0, 0);
        run_op("eq", 4'b1000, 32'd5, 32'd5, 32'd1, 0);
        run_op("ne", 4'b1001, 32'd5, 32'd5, 32'd0, 0);
        run_op("lui", 4'b1100, 32'd7, 32'hABCDE000, 32'hABCDE000, 0);
        run_op("op15", 4'b1111, 32'd7, 32'd9, 32'd0, 0);

        // Backpressure: result held, second request stalls.
        @(negedge clk);
        Operation = 4'b0100;
        SrcA      = 32'd10;
        SrcB      = 32'd3;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        Operation = 4'b0010;
        SrcA      = 32'hFF00FF00;
        SrcB      = 32'h0F0F0F0F;
        #1;
        chk("bp.vld", {31'd0, out_valid}, 32'd1);
        chk("bp.res0", ALUResult, 32'd7);
        held = ALUResult;
        repeat (5) begin
            @(negedge clk);
            #1;
            chk("bp.hold", ALUResult, held);
            chk("bp.stall", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        #1;
        chk("bp.idle", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("bp.next", ALUResult, 32'hF00FF00F);

        abort_shift("flush", 1'b0);
        abort_shift("reset", 1'b1);

        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            in_valid  = ($urandom_range(0, 2) != 0);
            Operation = 4'($urandom_range(0, 15));
            SrcA      = $urandom;
            SrcB      = ($urandom_range(0, 3) == 0) ? $urandom
                                                    : $urandom_range(0, 9);
            if ($urandom_range(0, 7) == 0) SrcB = SrcA;
            out_ready = ($urandom_range(0, 9) < 7);
            flush     = ($urandom_range(0, 59) == 0);
            rst_n     = ($urandom_range(0, 199) != 0);
        end
        @(negedge clk);
        rst_n    = 1'b1;
        flush    = 1'b0;
        in_valid = 1'b0;
        k = 0;
        while (k < 3) begin
            @(negedge clk);
            k++;
        end
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, errors);
        $finish;
    end

endmodule
